// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF        = 26;
  localparam int unsigned DEFAULT_HALF_DEF = 33554432;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Configuration handshake bundle: request from master, ready/error back from slave.
interface multi_clock_divider_if
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  localparam int unsigned CH_W = ch_w(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_ch, output cfg_half,
                  input  cfg_ready, input  cfg_err);
  modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_half,
                  output cfg_ready, output cfg_err);

endinterface

// File: rtl/divider_channel.sv
// One divider channel: half-period counter, 50% clock, rising-edge tick,
// and a pending half-period that is applied only at a full-period boundary.
module divider_channel #(
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 33554432
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             term_c;

  // Next-state: idle/disabled, first enabled cycle, counting, then config load.
  always_comb begin
    run_d      = run_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    term_c     = (cnt_q == (active_q - CNT_W'(1)));

    if (!en) begin
      run_d = 1'b0;
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        active_d = pend_val_q;
        pend_d   = 1'b0;
      end
    end else if (!run_q) begin
      // First enabled edge from idle only arms the channel, so the first
      // rising edge lands exactly H edges after enable is sampled.
      run_d = 1'b1;
      cnt_d = '0;
    end else if (term_c) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      if (clk_q && pend_q) begin
        active_d = pend_val_q;
        pend_d   = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A load on a running channel waits for the next period end.
    if (load) begin
      if (en) begin
        pend_d     = 1'b1;
        pend_val_d = load_half;
      end else begin
        active_d = load_half;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      active_q   <= CNT_W'(DEFAULT_HALF);
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: config decode, ready mux, error pulse.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_en,
  multi_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick
);

  localparam int unsigned CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] load_c;
  logic              ch_ok_c;
  logic              xfer_c;
  logic              legal_c;
  logic              err_q, err_d;

  // Handshake decode: accept, legality check, per-channel load strobe.
  always_comb begin
    ch_ok_c = (32'(cfg.cfg_ch) < NUM_CH);
    xfer_c  = cfg.cfg_valid && cfg.cfg_ready;
    legal_c = xfer_c && ch_ok_c && (cfg.cfg_half != '0);
    err_d   = xfer_c && !legal_c;
    for (int i = 0; i < NUM_CH; i++) begin
      load_c[i] = legal_c && (cfg.cfg_ch == CH_W'(i));
    end
  end

  // Ready drops only while the addressed channel holds a pending value.
  assign cfg.cfg_ready = ch_ok_c ? ~pend[cfg.cfg_ch] : 1'b1;
  assign cfg.cfg_err   = err_q;

  // One-cycle error pulse after an illegal accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    divider_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en        (ch_en[g]),
      .load      (load_c[g]),
      .load_half (cfg.cfg_half),
      .pending   (pend[g]),
      .clk_out   (clk_out[g]),
      .tick      (tick[g])
    );
  end

endmodule
